// File: rtl/axi_rd_burst_master.sv
// AXI4 read burst master: splits upstream beat requests into AXI bursts of at
// most MAX_AXI_LEN beats and streams the returned data into the line FIFO.
//
// state | meaning
// IDLE  | waiting for a request; applies fsync / pending reload
// LOAD  | size the next burst from the remaining beat count
// ADDR  | AR valid held until arready
// DATA  | accepting R beats until rlast
// FIN   | done pulse, back to IDLE
module axi_rd_burst_master #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 256,
    parameter int LSIZE       = 9,
    parameter int MAX_AXI_LEN = 64,
    parameter int ARID        = 0
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  fsync,
    input  logic [ADDR_WIDTH-1:0] frame_base,
    input  logic                  burst_req,
    input  logic                  tail_req,
    input  logic [LSIZE-1:0]      req_len,
    output logic                  resp,
    output logic                  done,
    output logic [3:0]            axi_arid,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic [2:0]            axi_arsize,
    output logic [1:0]            axi_arburst,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    output logic                  rd_err
);

    localparam int BPB = DATA_WIDTH / 8;
    localparam int BLW = 9;

    typedef enum logic [2:0] {IDLE, LOAD, ADDR, DATA, FIN} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [LSIZE-1:0]      remain_q;
    logic [BLW-1:0]        blen_q;
    logic [BLW-1:0]        blen_d;
    logic                  first_q;
    logic                  pend_q;
    logic                  resp_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic [7:0]            arlen_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  wr_en_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  rd_err_q;

    assign axi_arid     = 4'(ARID);
    assign axi_arsize   = 3'($clog2(BPB));
    assign axi_arburst  = 2'b01;
    assign resp         = resp_q;
    assign done         = done_q;
    assign axi_araddr   = araddr_q;
    assign axi_arlen    = arlen_q;
    assign axi_arvalid  = arvalid_q;
    assign axi_rready   = rready_q;
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign rd_err       = rd_err_q;

    always_comb begin
        blen_d = BLW'(remain_q);
        if (32'(remain_q) > MAX_AXI_LEN)
            blen_d = BLW'(MAX_AXI_LEN);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            remain_q  <= '0;
            blen_q    <= '0;
            first_q   <= 1'b0;
            pend_q    <= 1'b0;
            resp_q    <= 1'b0;
            done_q    <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            resp_q  <= 1'b0;
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;
            if (fsync && state_q != IDLE)
                pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    // A reload (live or deferred) always wins over a request.
                    if (fsync || pend_q) begin
                        ptr_q    <= frame_base;
                        rd_err_q <= 1'b0;
                        pend_q   <= 1'b0;
                    end else if (burst_req || tail_req) begin
                        remain_q <= req_len;
                        first_q  <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    if (remain_q == '0) begin
                        resp_q  <= first_q;
                        first_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end else begin
                        blen_q    <= blen_d;
                        araddr_q  <= ptr_q;
                        arlen_q   <= 8'(blen_d - BLW'(1));
                        arvalid_q <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (axi_arready) begin
                        arvalid_q <= 1'b0;
                        ptr_q     <= ptr_q + ADDR_WIDTH'(blen_q) * ADDR_WIDTH'(BPB);
                        remain_q  <= remain_q - LSIZE'(blen_q);
                        rready_q  <= 1'b1;
                        resp_q    <= first_q;
                        first_q   <= 1'b0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (axi_rvalid) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= axi_rdata;
                        if (axi_rresp != 2'b00)
                            rd_err_q <= 1'b1;
                        if (axi_rlast) begin
                            rready_q <= 1'b0;
                            if (remain_q != '0) begin
                                state_q <= LOAD;
                            end else begin
                                done_q  <= 1'b1;
                                state_q <= FIN;
                            end
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
